// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the fetch stage: opcodes, fetch FSM states, default reset PC.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        FS_REQ   = 1'b0,
        FS_VALID = 1'b1
    } fetch_state_t;

    // BEQ and BNE differ only in opcode bit 0, i.e. instr[26].
    function automatic logic is_bne(input logic [31:0] instr);
        return instr[26];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/ready bus between the fetch unit (master) and memory (slave).
interface instr_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump over taken branch over sequential, all modulo 2^32.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        jump,
    input  logic        alu_zero,
    output logic [31:0] next_pc
);

    logic [31:0] pc_plus4;
    logic [31:0] br_offset;
    logic [31:0] jump_target;
    logic        taken;

    assign pc_plus4    = pc + 32'd4;
    assign br_offset   = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign jump_target = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign taken       = is_bne(instr) ? !alu_zero : alu_zero;

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch && taken) begin
            next_pc = pc_plus4 + br_offset;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, imem req/ready handshake, instr hold until retire.
// Optional perf counters (retired_cnt, stall_cnt) enabled by defining FETCH_PERF_CNT_EN.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
`ifdef FETCH_PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_unit_if.master  imem,
    output logic [31:0]         instr,
    output logic                instr_valid,
    output logic [31:0]         pc,
    output logic [31:0]         pc_plus4,
    input  logic                retire,
    input  logic                branch,
    input  logic                jump,
    input  logic                alu_zero
`ifdef FETCH_PERF_CNT_EN
    , output logic [CNT_W-1:0]  retired_cnt
    , output logic [CNT_W-1:0]  stall_cnt
`endif
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         instr_valid_q, instr_valid_d;
    logic         imem_req_q, imem_req_d;
    logic [31:0]  next_pc;

    next_pc_calc u_next_pc (
        .pc       (pc_q),
        .instr    (instr_q),
        .branch   (branch),
        .jump     (jump),
        .alu_zero (alu_zero),
        .next_pc  (next_pc)
    );

    // A retire raises imem_req on the same edge that loads the new PC, giving
    // 2 cycles per instruction; only the post-reset fetch pays an idle REQ cycle.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        imem_req_d    = imem_req_q;
        case (state_q)
            FS_REQ: begin
                if (!imem_req_q) begin
                    imem_req_d = 1'b1;
                end else if (imem.imem_ready) begin
                    instr_d       = imem.imem_rdata;
                    instr_valid_d = 1'b1;
                    imem_req_d    = 1'b0;
                    state_d       = FS_VALID;
                end
            end
            FS_VALID: begin
                if (retire) begin
                    pc_d          = next_pc;
                    instr_valid_d = 1'b0;
                    imem_req_d    = 1'b1;
                    state_d       = FS_REQ;
                end
            end
            default: state_d = FS_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FS_REQ;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q    <= imem_req_d;
        end
    end

    assign imem.imem_req  = imem_req_q;
    assign imem.imem_addr = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = instr_valid_q;
    assign pc             = pc_q;
    assign pc_plus4       = pc_q + 32'd4;

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        retired_cnt_d = retired_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        if (state_q == FS_VALID && retire) begin
            retired_cnt_d = retired_cnt_q + CNT_W'(1);
        end
        if (state_q == FS_REQ && imem_req_q && !imem.imem_ready) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            retired_cnt_q <= retired_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign retired_cnt = retired_cnt_q;
    assign stall_cnt   = stall_cnt_q;
`endif

endmodule
